delay_line_ctrl: RTL

Run-time controller for a variable-depth DFF delay line (up to MAX_DEPTH stages, any data width). It configures the tap depth through a valid/ready port and sequences a zero-flush on every reconfiguration. It gates the shift enable from an upstream valid/ready handshake and tracks fill level, so the consumer knows when the tap output holds a real sample. It sits beside each delay-line instance inside the shift-register top and drives that instance's SHIFT_EN, CLR_EN and TAP_SEL.

---
 rtl/delay_line_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_ctrl
// Description : Run-time controller for a variable-depth DFF delay line.
//               Accepts a tap depth over a valid/ready config port, zero-
//               flushes the whole line on every accepted legal depth, gates
//               the shift enable from the upstream valid/ready handshake and
//               tracks fill level so OUT_VALID marks a real sample at the tap.
// Ports       : CLK, RST           clock / async active-high reset
//               CFG_VALID/READY    depth request handshake, CFG_DEPTH value
//               CFG_ERR            sticky flag: last accepted depth illegal
//               IN_VALID/IN_READY  upstream sample handshake
//               SHIFT_EN, CLR_EN   delay-line stage enable / stage-0 zeroing
//               TAP_SEL            output mux select (depth - 1)
//               OUT_VALID          tap holds a valid sample
//               BUSY               flush in progress
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_ctrl #(
  parameter int MAX_DEPTH = 32,
  parameter int DEPTH_W   = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CFG_VALID,
  input  logic [DEPTH_W-1:0] CFG_DEPTH,
  output logic               CFG_READY,
  output logic               CFG_ERR,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic               SHIFT_EN,
  output logic               CLR_EN,
  output logic [DEPTH_W-1:0] TAP_SEL,
  output logic               OUT_VALID,
  output logic               BUSY
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_flush = 2'd1;
  localparam logic [1:0] c_st_run   = 2'd2;

  localparam logic [DEPTH_W-1:0] c_max_depth = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] c_one       = DEPTH_W'(1);

  logic [1:0]         state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DEPTH_W-1:0] tap_sel_q, tap_sel_d;
  logic [DEPTH_W-1:0] fill_q, fill_d;
  logic [DEPTH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic               cfg_err_q, cfg_err_d;

  logic cfg_ready_w;
  logic cfg_fire_w;
  logic cfg_legal_w;
  logic in_ready_w;

  assign cfg_ready_w = (state_q != c_st_flush);
  assign in_ready_w  = (state_q == c_st_run);
  assign cfg_fire_w  = CFG_VALID & cfg_ready_w;
  assign cfg_legal_w = (CFG_DEPTH != '0) && (CFG_DEPTH <= c_max_depth);

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    tap_sel_d   = tap_sel_q;
    fill_d      = fill_q;
    flush_cnt_d = flush_cnt_q;
    cfg_err_d   = cfg_err_q;

    case (state_q)
      c_st_idle: begin
        state_d = c_st_idle;
      end
      c_st_flush: begin
        // Counter is loaded with MAX_DEPTH-1, so the exit on zero yields
        // exactly MAX_DEPTH cycles of zero shifting.
        if (flush_cnt_q == '0) begin
          state_d = c_st_run;
        end else begin
          flush_cnt_d = flush_cnt_q - c_one;
        end
      end
      c_st_run: begin
        if (IN_VALID && (fill_q != depth_q)) begin
          fill_d = fill_q + c_one;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    // A legal config overrides the fill update above: a sample shifted on
    // the same edge is wiped by the flush that follows.
    if (cfg_fire_w) begin
      if (cfg_legal_w) begin
        depth_d     = CFG_DEPTH;
        tap_sel_d   = CFG_DEPTH - c_one;
        cfg_err_d   = 1'b0;
        fill_d      = '0;
        flush_cnt_d = c_max_depth - c_one;
        state_d     = c_st_flush;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= c_st_idle;
      depth_q     <= c_one;
      tap_sel_q   <= '0;
      fill_q      <= '0;
      flush_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      tap_sel_q   <= tap_sel_d;
      fill_q      <= fill_d;
      flush_cnt_q <= flush_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign CFG_READY = cfg_ready_w;
  assign CFG_ERR   = cfg_err_q;
  assign IN_READY  = in_ready_w;
  assign BUSY      = (state_q == c_st_flush);
  assign CLR_EN    = (state_q == c_st_flush);
  assign SHIFT_EN  = (state_q == c_st_flush) | (in_ready_w & IN_VALID);
  assign TAP_SEL   = tap_sel_q;
  // Registers only: no input reaches OUT_VALID combinationally.
  assign OUT_VALID = in_ready_w & (fill_q == depth_q);

endmodule
`default_nettype wire
